// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared types and constants for the tick scheduler
package counter_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_PWIDTH = 4;

endpackage

// File: rtl/counter_ce_clr.sv
// rtl/counter_ce_clr.sv - W-bit register with incrementer, carry-out, enable and sync clear
module counter_ce_clr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ce,
   input  logic         clr,
   output logic [W-1:0] q,
   output logic         carry
);

   logic [W-1:0] sum;

   // carry reports that the next increment overflows back to zero
   assign {carry, sum} = {1'b0, q} + {{W{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (ce) begin
         q <= sum;
      end
   end

endmodule

// File: rtl/counter_tick_sched.sv
// rtl/counter_tick_sched.sv - programmable one-shot/periodic tick generator with prescaler
module counter_tick_sched
   import counter_sched_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int PWIDTH = DEF_PWIDTH
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic              STOP,
   input  logic              MODE,
   input  logic [WIDTH-1:0]  LOAD_VAL,
   input  logic [PWIDTH-1:0] PRESCALE,
   output logic              BUSY,
   output logic              TICK,
   output logic              DONE,
   output logic [WIDTH-1:0]  COUNT,
   output logic              CE
);

   state_e              state;
   logic                mode_q;
   logic [WIDTH-1:0]    load_q;
   logic [PWIDTH-1:0]   presc_q;
   logic [PWIDTH-1:0]   presc_cnt;
   logic                presc_carry;
   logic                cnt_carry;
   logic                start_acc;
   logic                run;

   assign run       = (state == RUN);
   assign start_acc = (state == IDLE) && START && !STOP;

   assign BUSY = run;
   assign DONE = (state == FIN);
   assign CE   = run && (presc_cnt == presc_q);
   assign TICK = CE && (COUNT == load_q);

   // At the all-ones terminal the wrap comes from overflow, so clear only when no carry
   counter_ce_clr #(.W(PWIDTH)) u_presc (
      .clk   (CLK),
      .reset (RESET),
      .ce    (run),
      .clr   (start_acc || (CE && !presc_carry)),
      .q     (presc_cnt),
      .carry (presc_carry)
   );

   counter_ce_clr #(.W(WIDTH)) u_count (
      .clk   (CLK),
      .reset (RESET),
      .ce    (CE),
      .clr   (start_acc || (TICK && !cnt_carry)),
      .q     (COUNT),
      .carry (cnt_carry)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         mode_q  <= MODE_ONESHOT;
         load_q  <= '0;
         presc_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_acc) begin
                  state   <= RUN;
                  mode_q  <= MODE;
                  load_q  <= LOAD_VAL;
                  presc_q <= PRESCALE;
               end
            end
            RUN: begin
               if (STOP || (TICK && (mode_q == MODE_ONESHOT))) begin
                  state <= FIN;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_tick_sched.sv
// tb/tb_counter_tick_sched.sv - scoreboard bench with arithmetic reference model
module tb_counter_tick_sched;

   localparam int W  = 4;
   localparam int PW = 4;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          START;
   logic          STOP;
   logic          MODE;
   logic [W-1:0]  LOAD_VAL;
   logic [PW-1:0] PRESCALE;
   logic          BUSY;
   logic          TICK;
   logic          DONE;
   logic [W-1:0]  COUNT;
   logic          CE;

   counter_tick_sched #(.WIDTH(W), .PWIDTH(PW)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .STOP     (STOP),
      .MODE     (MODE),
      .LOAD_VAL (LOAD_VAL),
      .PRESCALE (PRESCALE),
      .BUSY     (BUSY),
      .TICK     (TICK),
      .DONE     (DONE),
      .COUNT    (COUNT),
      .CE       (CE)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [7:0] v;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [W-1:0] held;

   exp_t       mon_e;
   logic [7:0] mon_act;

   // expected vector layout: {BUSY, TICK, DONE, CE, COUNT}
   function automatic logic [7:0] vec(input bit b, input bit t, input bit d, input bit c, input int cnt);
      logic [3:0] c4;
      c4 = 4'(cnt);
      return {b, t, d, c, c4};
   endfunction

   task automatic push(input int c, input logic [7:0] v);
      exp_t e;
      e.c = c;
      e.v = v;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      while (sb.size() > 0 && sb[0].c <= cyc) begin
         mon_e   = sb.pop_front();
         mon_act = {BUSY, TICK, DONE, CE, COUNT};
         n_checks++;
         if (mon_e.c == cyc && mon_act === mon_e.v)
            n_pass++;
         else
            $display("FAIL outputs@cycle%0d busy/tick/done/ce/count: got %b required %b (entry for cycle %0d)",
                     cyc, mon_act, mon_e.v, mon_e.c);
      end
   end

   task automatic idle_cycles(input int k, input bit both);
      for (int j = 0; j < k; j++) begin
         START    = both;
         STOP     = both;
         MODE     = 1'($urandom);
         LOAD_VAL = W'($urandom);
         PRESCALE = PW'($urandom);
         push(cyc + 1, vec(0, 0, 0, 0, int'(held)));
         step();
      end
      START = 1'b0;
      STOP  = 1'b0;
   endtask

   // Model: RUN cycle i has prescaler i mod (P+1) and count (i div (P+1)) mod (L+1)
   task automatic do_txn(input bit m, input int l, input int p, input int s, input int rst_at, input int idle_n);
      int q, r, n, cnt;
      bit ce;
      q = p + 1;
      r = m ? 100000 : (l + 1) * q;
      if (s >= 0 && s + 1 < r) r = s + 1;
      if (rst_at >= 0 && rst_at + 1 < r) r = rst_at + 1;
      n = cyc;
      START    = 1'b1;
      STOP     = 1'b0;
      MODE     = m;
      LOAD_VAL = W'(l);
      PRESCALE = PW'(p);
      for (int i = 0; i < r; i++) begin
         ce  = ((i % q) == p);
         cnt = (i / q) % (l + 1);
         push(n + 1 + i, vec(1, ce && (cnt == l), 0, ce, cnt));
      end
      if (rst_at >= 0 && rst_at + 1 == r) begin
         held = '0;
         push(n + r + 1, vec(0, 0, 0, 0, 0));
      end else begin
         held = W'((r / q) % (l + 1));
         push(n + r + 1, vec(0, 0, 1, 0, int'(held)));
      end
      for (int j = 1; j <= idle_n; j++) push(n + r + 1 + j, vec(0, 0, 0, 0, int'(held)));
      step();
      for (int i = 0; i < r; i++) begin
         START    = 1'($urandom);
         MODE     = 1'($urandom);
         LOAD_VAL = W'($urandom);
         PRESCALE = PW'($urandom);
         STOP     = (i == s);
         RESET    = (i == rst_at);
         step();
      end
      RESET = 1'b0;
      START = (rst_at >= 0) ? 1'b0 : 1'($urandom);
      STOP  = 1'($urandom);
      step();
      for (int j = 1; j < idle_n; j++) begin
         START = 1'b0;
         STOP  = 1'($urandom);
         step();
      end
      START = 1'b0;
      STOP  = 1'b0;
   endtask

   initial begin
      int m, l, p, s, q;
      RESET    = 1'b1;
      START    = 1'b0;
      STOP     = 1'b0;
      MODE     = 1'b0;
      LOAD_VAL = '0;
      PRESCALE = '0;
      held     = '0;
      for (int k = 1; k <= 3; k++) push(k, vec(0, 0, 0, 0, 0));
      step();
      step();
      step();
      RESET = 1'b0;

      idle_cycles(20, 1'b0);
      do_txn(1'b0, 3, 0, -1, -1, 2);
      do_txn(1'b1, 2, 1, 31, -1, 2);
      do_txn(1'b1, 15, 0, 40, -1, 2);
      do_txn(1'b1, 1, 0, 5, -1, 3);
      idle_cycles(4, 1'b1);
      do_txn(1'b1, 9, 0, -1, 5, 3);
      do_txn(1'b0, 15, 15, -1, -1, 1);

      for (int t = 0; t < 30; t++) begin
         m = $urandom_range(0, 1);
         l = $urandom_range(0, 15);
         p = $urandom_range(0, 7);
         q = (l + 1) * (p + 1);
         if (m == 1)
            s = $urandom_range(0, 80);
         else
            s = ($urandom_range(0, 1) == 1) ? $urandom_range(0, q) : -1;
         do_txn(1'(m), l, p, s, -1, $urandom_range(1, 4));
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), 1'b1);
      end

      for (int k = 0; k < 20 && sb.size() > 0; k++) step();
      if (sb.size() > 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
